// File: rtl/intersection_pkg.sv
// Shared definitions for the intersection phase sequencer.
//   state_t        : controller state codes, also driven out on the phase debug port
//   LT_R/LT_G/LT_Y : one-hot lamp codes, index 0 = red, 1 = green, 2 = yellow
//   DEF_*          : default dwell times and timer width
package intersection_pkg;

  typedef enum logic [2:0] {
    AR_M = 3'd0,  // all-red clearance before main green
    MG   = 3'd1,  // main green (rest state)
    MY   = 3'd2,  // main yellow
    AR_S = 3'd3,  // all-red clearance before side green
    SG   = 3'd4,  // side green
    SY   = 3'd5   // side yellow
  } state_t;

  localparam logic [0:2] LT_R = 3'b100;
  localparam logic [0:2] LT_G = 3'b010;
  localparam logic [0:2] LT_Y = 3'b001;

  localparam int DEF_GREEN_MIN = 8;
  localparam int DEF_SIDE_T    = 6;
  localparam int DEF_YELLOW_T  = 3;
  localparam int DEF_ALLRED_T  = 2;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the phase sequencer.
// Ports:
//   clk    in  rising-edge clock
//   rst    in  asynchronous active-high reset, count -> 0
//   clear  in  synchronous clear to 0 (wins over enable)
//   enable in  count up by one, holding at all-ones
//   count  out current count
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_ctrl.sv
// Moore phase sequencer sharing one intersection between a main road and a
// side road. Main road rests in green; side-road (and optionally pedestrian)
// requests are latched and served after the minimum main-green dwell.
// Optional feature macro: PED_WALK_EN (pedestrian request/walk support).
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   side_req   in   side-road sensor, sampled every cycle
//   ped_req    in   pedestrian button (ignored unless PED_WALK_EN)
//   main_light out  [0:2] main lamps, bit0=R bit1=G bit2=Y
//   side_light out  [0:2] side lamps, same encoding
//   ped_walk   out  walk indication, only ever high in SG
//   phase      out  current state code (debug)
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN = DEF_GREEN_MIN,
  parameter int SIDE_T    = DEF_SIDE_T,
  parameter int YELLOW_T  = DEF_YELLOW_T,
  parameter int ALLRED_T  = DEF_ALLRED_T,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [0:2] main_light,
  output logic [0:2] side_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  // Timer value on the last cycle of each dwell.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SIDE_LAST   = CNT_W'(SIDE_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic             timer_clear;
  logic             enter_sg;
  logic             side_pend;
  logic             ped_pend;

  // Timer restarts from 0 on every state change, so timer counts cycles
  // already spent in the current state.
  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (1'b1),
    .count  (timer)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= AR_M;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      AR_M: if (timer == ALLRED_LAST) state_next = MG;
      MG:   if ((timer >= GREEN_LAST) && (side_pend || ped_pend)) state_next = MY;
      MY:   if (timer == YELLOW_LAST) state_next = AR_S;
      AR_S: if (timer == ALLRED_LAST) state_next = SG;
      SG:   if (timer == SIDE_LAST)   state_next = SY;
      SY:   if (timer == YELLOW_LAST) state_next = AR_M;
      default: state_next = AR_M;  // codes 6/7 recover to a safe all-red
    endcase
  end

  assign timer_clear = (state_next != state);
  assign enter_sg    = (state != SG) && (state_next == SG);

  // Requests are served by the SG entry; a request in the entry cycle
  // itself is dropped (clear wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      side_pend <= 1'b0;
    end else begin
      side_pend <= enter_sg ? 1'b0 : (side_pend | side_req);
    end
  end

`ifdef PED_WALK_EN
  // walk_q remembers whether this SG visit was earned by a pedestrian.
  logic walk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_pend <= 1'b0;
      walk_q   <= 1'b0;
    end else begin
      ped_pend <= enter_sg ? 1'b0 : (ped_pend | ped_req);
      if (enter_sg) walk_q <= ped_pend;
    end
  end

  assign ped_walk = (state == SG) && walk_q;
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pend       = 1'b0;
  assign ped_walk       = 1'b0;
`endif

  // Pure decode of the state register.
  always_comb begin
    main_light = LT_R;
    side_light = LT_R;
    case (state)
      MG:      main_light = LT_G;
      MY:      main_light = LT_Y;
      SG:      side_light = LT_G;
      SY:      side_light = LT_Y;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Directed bench for intersection_ctrl with short dwell times
// (GREEN_MIN=4 SIDE_T=3 YELLOW_T=2 ALLRED_T=1). Honors PED_WALK_EN.
module tb_intersection_ctrl;

  localparam int GREEN_MIN = 4;
  localparam int SIDE_T    = 3;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int CNT_W     = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       side_req;
  logic       ped_req;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       ped_walk;
  logic [2:0] phase;

  int total = 0;
  int bad   = 0;
  int seq_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  intersection_ctrl #(
    .GREEN_MIN (GREEN_MIN),
    .SIDE_T    (SIDE_T),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected lamp codes for a phase code.
  function automatic logic [0:2] exp_main(input int ph);
    case (ph)
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [0:2] exp_side(input int ph);
    case (ph)
      4:       return 3'b010;
      5:       return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int ph, input logic walk);
    logic [2:0] ph_exp;
    logic [0:2] m_exp;
    logic [0:2] s_exp;
    ph_exp = 3'(ph);
    m_exp  = exp_main(ph);
    s_exp  = exp_side(ph);
    total++;
    assert (phase === ph_exp) else begin
      bad++;
      $error("FAIL %s phase got=%0d exp=%0d", tag, phase, ph_exp);
    end
    total++;
    assert (main_light === m_exp) else begin
      bad++;
      $error("FAIL %s main_light got=%b exp=%b", tag, main_light, m_exp);
    end
    total++;
    assert (side_light === s_exp) else begin
      bad++;
      $error("FAIL %s side_light got=%b exp=%b", tag, side_light, s_exp);
    end
    total++;
    assert (ped_walk === walk) else begin
      bad++;
      $error("FAIL %s ped_walk got=%b exp=%b", tag, ped_walk, walk);
    end
  endtask

  // Step once per queued phase and check it; walk_sg is the expected walk in SG.
  task automatic play(input string tag, input logic walk_sg);
    foreach (seq_q[i]) begin
      step;
      check(tag, seq_q[i], (seq_q[i] == 4) ? walk_sg : 1'b0);
    end
  endtask

  // Leaves the DUT in MG cycle 1.
  task automatic do_reset(input string tag);
    rst      = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;
    step;
    step;
    check({tag, "_rst"}, 0, 1'b0);
    rst = 1'b0;
    check({tag, "_rel"}, 0, 1'b0);
    step;
    check({tag, "_mg1"}, 1, 1'b0);
  endtask

  initial begin
    rst      = 1'b1;
    side_req = 1'b0;
    ped_req  = 1'b0;

    // 1: no requests, main green held
    do_reset("t1");
    repeat (50) begin
      step;
      check("t1_mg_hold", 1, 1'b0);
    end

    // 2: single side pulse in MG cycle 1
    do_reset("t2");
    side_req = 1'b1;
    step;
    side_req = 1'b0;
    check("t2_mg2", 1, 1'b0);
    seq_q = {1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0, 1, 1, 1, 1, 1, 1};
    play("t2_seq", 1'b0);

    // 3: side_req held high, two full rounds with 4-cycle MG
    do_reset("t3");
    side_req = 1'b1;
    seq_q = {1, 1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0,
             1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0, 1};
    play("t3_seq", 1'b0);
    side_req = 1'b0;

    // 4: request coincident with SG entry is absorbed
    do_reset("t4");
    side_req = 1'b1;
    step;
    side_req = 1'b0;
    check("t4_mg2", 1, 1'b0);
    seq_q = {1, 1, 2, 2, 3};
    play("t4_pre", 1'b0);
    side_req = 1'b1;
    step;
    side_req = 1'b0;
    check("t4_sg1", 4, 1'b0);
    seq_q = {4, 4, 5, 5, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    play("t4_post", 1'b0);

    // 5: async reset in SG cycle 2 with a request pending
    do_reset("t5");
    side_req = 1'b1;
    step;
    side_req = 1'b0;
    check("t5_mg2", 1, 1'b0);
    seq_q = {1, 1, 2, 2, 3, 4};
    play("t5_pre", 1'b0);
    side_req = 1'b1;
    step;
    side_req = 1'b0;
    check("t5_sg2", 4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async", 0, 1'b0);
    step;
    check("t5_hold", 0, 1'b0);
    rst = 1'b0;
    check("t5_rel", 0, 1'b0);
    seq_q = {1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    play("t5_post", 1'b0);

    // 6: pedestrian request only
    do_reset("t6");
    ped_req = 1'b1;
    step;
    ped_req = 1'b0;
    check("t6_mg2", 1, 1'b0);
`ifdef PED_WALK_EN
    seq_q = {1, 1, 2, 2, 3, 4, 4, 4, 5, 5, 0, 1, 1, 1, 1, 1, 1};
    play("t6_seq", 1'b1);
`else
    seq_q = {1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    play("t6_seq", 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
